// File: rtl/reg_file_dump.sv
// reg_file_dump: read-side sequencer for a 32x32 register file.
// On a start pulse it walks registers FIRST_REG..LAST_REG through one read port,
// capturing each word and streaming it out on a valid/ready interface with its index.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      dump request, sampled only while idle
//   busy       high while a dump is in progress (load, send, done)
//   done       one-cycle pulse after the last word is accepted
//   rd_addr    register file read address (registered pointer)
//   rd_data    register file read data, combinational from rd_addr
//   out_valid  out_index/out_data hold a word
//   out_ready  consumer accepts the word on out_valid && out_ready
//   out_index  register number of out_data
//   out_data   captured register contents
module reg_file_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data
);

  if (LAST_REG < FIRST_REG || LAST_REG > 31) begin : g_bad_range
    $error("reg_file_dump: need FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FirstPtr = 5'(FIRST_REG);
  localparam logic [4:0] LastPtr  = 5'(LAST_REG);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_index_q, out_index_d;
  logic [31:0] out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d   = FirstPtr;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Snapshot is the value read this cycle; a same-edge write is not seen.
        out_data_d  = rd_data;
        out_index_d = ptr_q;
        out_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          // Stop at LastPtr so the 5-bit pointer never wraps, even for LAST_REG = 31.
          if (ptr_q == LastPtr) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q + 5'd1;
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        ptr_d   = FirstPtr;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= FirstPtr;
      out_valid_q <= 1'b0;
      out_index_q <= 5'd0;
      out_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_addr   = ptr_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: a default-range instance and a single-register
// instance (FIRST_REG = LAST_REG = 5) share a behavioural register file.
module tb_reg_file_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, out_valid;
  logic [4:0]  rd_addr, out_index;
  logic [31:0] rd_data, out_data;

  logic        start_b = 1'b0;
  logic        out_ready_b = 1'b0;
  logic        busy_b, done_b, out_valid_b;
  logic [4:0]  rd_addr_b, out_index_b;
  logic [31:0] rd_data_b, out_data_b;

  // Register file: one writer process; preload copies the reference contents in.
  logic [31:0] rf [32];
  logic [31:0] model_rf [32];
  logic        preload = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = 5'd0;
  logic [31:0] wd = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  int          acc_idx [$];
  logic [31:0] acc_dat [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) rf <= model_rf;
    else if (we) rf[wa] <= wd;
  end

  assign rd_data   = rf[rd_addr];
  assign rd_data_b = rf[rd_addr_b];

  reg_file_dump dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data)
  );

  reg_file_dump #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .busy      (busy_b),
    .done      (done_b),
    .rd_addr   (rd_addr_b),
    .rd_data   (rd_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_index (out_index_b),
    .out_data  (out_data_b)
  );

  task automatic load_rf(input bit randomize);
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = randomize ? $urandom : (32'h1000_0000 + i);
    end
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Runs one dump on the default instance and collects accepted words. Cycle numbering:
  // the cycle in which start is sampled is cycle 1.
  task automatic run_dump(input int stall_pct, input int stall_idx, input int restart_idx,
                          input int wr_idx, input logic [31:0] wr_val,
                          output int done_cnt, output int done_cyc, output int hold_viol,
                          output int stall_cyc);
    logic        pv, pacc;
    logic [4:0]  pidx;
    logic [31:0] pdat;
    int          stall_left;
    acc_idx.delete();
    acc_dat.delete();
    done_cnt = 0; done_cyc = 0; hold_viol = 0; stall_cyc = 0; stall_left = 5;
    pv = 1'b0; pacc = 1'b0; pidx = 5'd0; pdat = 32'd0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int j = 1; j <= 3000; j++) begin
      @(negedge clk);
      start = 1'b0;
      we = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = j + 1;
      end
      if (out_valid && pv && !pacc && (out_index !== pidx || out_data !== pdat)) hold_viol++;
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      if (out_valid && int'(out_index) == stall_idx) begin
        stall_cyc++;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end
      end
      if (out_valid && int'(out_index) == restart_idx) start = 1'b1;
      // Load cycle for wr_idx: write lands on the same edge that snapshots it.
      if (busy && !out_valid && !done && int'(rd_addr) == wr_idx) begin
        we = 1'b1;
        wa = wr_idx[4:0];
        wd = wr_val;
      end
      pv = out_valid; pidx = out_index; pdat = out_data;
      pacc = out_valid && out_ready;
      if (pacc) begin
        acc_idx.push_back(int'(out_index));
        acc_dat.push_back(out_data);
      end
      if (done_cyc != 0 && j + 1 >= done_cyc + 4) break;
    end
    start = 1'b0;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/valid=%b required 000", {busy, done, out_valid});
    end
    n_checks++;
    if (out_index !== 5'd0 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: index=%0d data=%h required 0/0", out_index, out_data);
    end
    n_checks++;
    if (rd_addr !== 5'd0 || rd_addr_b !== 5'd5) begin
      n_fail++;
      $display("FAIL reset_ptr: rd_addr=%0d rd_addr_b=%0d required 0/5", rd_addr, rd_addr_b);
    end
  endtask

  task automatic test_full_dump();
    int dc, dcy, hv, sc;
    load_rf(1'b0);
    run_dump(0, -1, -1, -1, 32'd0, dc, dcy, hv, sc);
    n_checks++;
    if (acc_idx.size() != 32) begin
      n_fail++;
      $display("FAIL full_count: words=%0d required 32", acc_idx.size());
    end
    for (int i = 0; i < acc_idx.size() && i < 32; i++) begin
      n_checks++;
      if (acc_idx[i] != i || acc_dat[i] !== 32'h1000_0000 + i) begin
        n_fail++;
        $display("FAIL full_word%0d: index=%0d data=%h required %0d/%h", i, acc_idx[i],
                 acc_dat[i], i, 32'h1000_0000 + i);
      end
    end
    n_checks++;
    if (dc != 1 || dcy != 66) begin
      n_fail++;
      $display("FAIL full_done: pulses=%0d cycle=%0d required 1/66", dc, dcy);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_stall();
    int dc, dcy, hv, sc;
    run_dump(0, 3, -1, -1, 32'd0, dc, dcy, hv, sc);
    n_checks++;
    if (hv != 0 || sc != 6) begin
      n_fail++;
      $display("FAIL stall_hold: violations=%0d valid_cycles_idx3=%0d required 0/6", hv, sc);
    end
    n_checks++;
    if (acc_idx.size() != 32 || dc != 1) begin
      n_fail++;
      $display("FAIL stall_count: words=%0d done=%0d required 32/1", acc_idx.size(), dc);
    end
    for (int i = 0; i < acc_idx.size() && i < 32; i++) begin
      n_checks++;
      if (acc_idx[i] != i || acc_dat[i] !== model_rf[i]) begin
        n_fail++;
        $display("FAIL stall_word%0d: index=%0d data=%h required %0d/%h", i, acc_idx[i],
                 acc_dat[i], i, model_rf[i]);
      end
    end
  endtask

  task automatic test_write_race();
    int dc, dcy, hv, sc;
    run_dump(0, -1, -1, 7, 32'hDEAD_BEEF, dc, dcy, hv, sc);
    n_checks++;
    if (acc_dat.size() != 32 || acc_dat[7] !== 32'h1000_0007) begin
      n_fail++;
      $display("FAIL race_first: words=%0d data7=%h required 32/10000007", acc_dat.size(),
               acc_dat[7]);
    end
    model_rf[7] = 32'hDEAD_BEEF;
    run_dump(0, -1, -1, -1, 32'd0, dc, dcy, hv, sc);
    n_checks++;
    if (acc_dat.size() != 32 || acc_dat[7] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL race_second: words=%0d data7=%h required 32/deadbeef", acc_dat.size(),
               acc_dat[7]);
    end
  endtask

  task automatic test_reset_mid();
    int dc, dcy, hv, sc, dcnt;
    bit seen;
    seen = 1'b0; dcnt = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcnt++;
      if (out_valid && out_index == 5'd12) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid_reach: index 12 seen=%0d required 1", seen);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b busy=%b required 0/0", out_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    n_checks++;
    if (dcnt != 0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: pulses=%0d required 0", dcnt);
    end
    run_dump(0, -1, -1, -1, 32'd0, dc, dcy, hv, sc);
    n_checks++;
    if (acc_idx.size() != 32 || acc_idx[0] != 0 || dc != 1) begin
      n_fail++;
      $display("FAIL rstmid_restart: words=%0d first=%0d done=%0d required 32/0/1",
               acc_idx.size(), acc_idx.size() > 0 ? acc_idx[0] : -1, dc);
    end
  endtask

  task automatic test_single_reg();
    int wc, dc, bc, widx;
    logic [31:0] wdat;
    wc = 0; dc = 0; bc = 0; widx = -1; wdat = 32'd0;
    @(negedge clk);
    start_b = 1'b1;
    out_ready_b = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (busy_b) bc++;
      if (done_b) dc++;
      if (out_valid_b) begin
        wc++;
        widx = int'(out_index_b);
        wdat = out_data_b;
      end
    end
    out_ready_b = 1'b0;
    n_checks++;
    if (wc != 1 || widx != 5 || wdat !== model_rf[5]) begin
      n_fail++;
      $display("FAIL single_word: words=%0d index=%0d data=%h required 1/5/%h", wc, widx,
               wdat, model_rf[5]);
    end
    n_checks++;
    if (dc != 1 || bc != 3) begin
      n_fail++;
      $display("FAIL single_busy: done=%0d busy_cycles=%0d required 1/3", dc, bc);
    end
  endtask

  task automatic test_restart_ignored();
    int dc, dcy, hv, sc;
    run_dump(0, -1, 20, -1, 32'd0, dc, dcy, hv, sc);
    n_checks++;
    if (acc_idx.size() != 32 || dc != 1) begin
      n_fail++;
      $display("FAIL restart_count: words=%0d done=%0d required 32/1", acc_idx.size(), dc);
    end
    for (int i = 0; i < acc_idx.size() && i < 32; i++) begin
      n_checks++;
      if (acc_idx[i] != i) begin
        n_fail++;
        $display("FAIL restart_idx%0d: index=%0d required %0d", i, acc_idx[i], i);
      end
    end
  endtask

  task automatic test_random_backpressure();
    int dc, dcy, hv, sc;
    load_rf(1'b1);
    for (int r = 0; r < 3; r++) begin
      run_dump(20 + 20 * r, -1, -1, -1, 32'd0, dc, dcy, hv, sc);
      n_checks++;
      if (acc_idx.size() != 32 || dc != 1 || hv != 0) begin
        n_fail++;
        $display("FAIL rand%0d_count: words=%0d done=%0d holdviol=%0d required 32/1/0", r,
                 acc_idx.size(), dc, hv);
      end
      for (int i = 0; i < acc_idx.size() && i < 32; i++) begin
        n_checks++;
        if (acc_idx[i] != i || acc_dat[i] !== model_rf[i]) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: index=%0d data=%h required %0d/%h", r, i,
                   acc_idx[i], acc_dat[i], i, model_rf[i]);
        end
      end
    end
  endtask

  // Start held high: next dump begins in the idle cycle right after done.
  task automatic test_back_to_back();
    int dcyc [$];
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (done) dcyc.push_back(j + 1);
      if (dcyc.size() == 2) break;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dcyc.size() != 2 || dcyc[0] != 66 || dcyc[1] != 132) begin
      n_fail++;
      $display("FAIL b2b_done: pulses=%0d first=%0d second=%0d required 2/66/132",
               dcyc.size(), dcyc.size() > 0 ? dcyc[0] : -1, dcyc.size() > 1 ? dcyc[1] : -1);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_write_race();
    test_reset_mid();
    test_single_reg();
    test_restart_ignored();
    test_random_backpressure();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
